// File: rtl/coll_pkg.sv
// Shared types and helpers for the clk350 capture controller.
package coll_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      COLLECT,
      DRAIN,
      DONE
   } coll_state_t;

   localparam int unsigned TSTAMP_W = 16;

   // Ceiling log2, used for pointer and level widths.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned x = 1; x < v; x = x << 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/coll_ring_buf.sv
// Ring buffer for captured samples: storage, wrapping pointers, fill level,
// and a registered show-ahead read port that always presents the oldest entry.
module coll_ring_buf
   import coll_pkg::*;
#(
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 1024
) (
   input  logic                  clk350,
   input  logic                  rstn,
   input  logic                  clr,
   input  logic                  wr_req,
   input  logic [W-1:0]          wr_data,
   input  logic                  rd_rdy,
   output logic [W-1:0]          rd_data,
   output logic                  rd_vld,
   output logic [clog2(DEPTH):0] level,
   output logic                  wr_acc,
   output logic                  drop
);

   localparam int unsigned AW = clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_ptr_nxt;
   logic          full;
   logic          empty;
   logic          rd_fire;

   // Handshake qualification; a full buffer still accepts a write when a read frees a slot
   always_comb begin
      empty      = (level == '0);
      full       = (level == LW'(DEPTH));
      rd_vld     = !empty;
      rd_fire    = rd_vld & rd_rdy;
      wr_acc     = wr_req & (!full | rd_fire);
      drop       = wr_req & !wr_acc;
      rd_ptr_nxt = rd_ptr + AW'(1);
   end

   // Sample storage, left unreset
   always_ff @(posedge clk350) begin
      if (wr_acc) mem[wr_ptr] <= wr_data;
   end

   // Pointers, level, and the registered head-of-queue output
   always_ff @(posedge clk350 or posedge rstn) begin
      if (rstn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         rd_data <= '0;
      end else if (clr) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
      end else begin
         if (wr_acc)  wr_ptr <= wr_ptr + AW'(1);
         if (rd_fire) rd_ptr <= rd_ptr_nxt;
         case ({wr_acc, rd_fire})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         // Head comes straight from the write when the queue is, or is about to be, empty;
         // otherwise it advances to the next stored entry on a read and holds while stalled.
         if (wr_acc && (empty || (rd_fire && level == LW'(1))))
            rd_data <= wr_data;
         else if (rd_fire)
            rd_data <= mem[rd_ptr_nxt];
      end
   end

endmodule

// File: rtl/coll_capture_ctrl.sv
// Capture-window controller: synchronises StartColl from clk200, runs the
// Collect window, buffers qualified samples and drains them over valid/ready.
// Optional macro COLL_TSTAMP_EN tags each entry with a 16-bit saturating
// window-cycle timestamp in the upper bits of rd_data.
module coll_capture_ctrl
   import coll_pkg::*;
#(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WIN_W       = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                         clk350,
   input  logic                         rstn,
   input  logic                         start_coll_async,
   input  logic [WIN_W-1:0]             win_len,
   input  logic [DATA_W-1:0]            din,
   input  logic                         din_vld,
   output logic                         collect,
`ifdef COLL_TSTAMP_EN
   output logic [DATA_W+TSTAMP_W-1:0]   rd_data,
`else
   output logic [DATA_W-1:0]            rd_data,
`endif
   output logic                         rd_vld,
   input  logic                         rd_rdy,
   output logic [clog2(DEPTH):0]        level,
   output logic                         overflow,
   output logic                         coll_done
);

`ifdef COLL_TSTAMP_EN
   localparam int unsigned ENT_W = DATA_W + TSTAMP_W;
`else
   localparam int unsigned ENT_W = DATA_W;
`endif

   coll_state_t            state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   start;
   logic                   start_d;
   logic                   rise;
   logic [WIN_W-1:0]       len_q;
   logic [WIN_W-1:0]       win_cnt;
   logic [ENT_W-1:0]       entry;
   logic                   buf_clr;
   logic                   wr_acc;
   logic                   drop;

   // StartColl synchroniser plus one register for rising-edge detection
   always_ff @(posedge clk350 or posedge rstn) begin
      if (rstn) begin
         sync_q  <= '0;
         start_d <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], start_coll_async};
         start_d <= start;
      end
   end

   // Edge detect and buffer clear strobe
   always_comb begin
      start   = sync_q[SYNC_STAGES-1];
      rise    = start & !start_d;
      buf_clr = (state == ARM);
   end

`ifdef COLL_TSTAMP_EN
   logic [TSTAMP_W-1:0] ts_q;

   // Window cycle offset, tracking win_cnt but saturating at all-ones
   always_ff @(posedge clk350 or posedge rstn) begin
      if (rstn)
         ts_q <= '0;
      else if (state == ARM)
         ts_q <= '0;
      else if (state == COLLECT && ts_q != '1)
         ts_q <= ts_q + TSTAMP_W'(1);
   end

   // Stored entry is timestamp over sample
   always_comb entry = {ts_q, din};
`else
   // Stored entry is the bare sample
   always_comb entry = din;
`endif

   // Run sequencing, window counting and registered status outputs
   always_ff @(posedge clk350 or posedge rstn) begin
      if (rstn) begin
         state     <= IDLE;
         len_q     <= '0;
         win_cnt   <= '0;
         collect   <= 1'b0;
         overflow  <= 1'b0;
         coll_done <= 1'b0;
      end else begin
         coll_done <= 1'b0;
         if (drop) overflow <= 1'b1;
         case (state)
            IDLE: begin
               if (rise) state <= ARM;
            end
            ARM: begin
               len_q    <= win_len;
               win_cnt  <= '0;
               overflow <= 1'b0;
               if (win_len == '0) begin
                  state     <= DONE;
                  coll_done <= 1'b1;
               end else begin
                  state   <= COLLECT;
                  collect <= 1'b1;
               end
            end
            COLLECT: begin
               win_cnt <= win_cnt + WIN_W'(1);
               if (win_cnt == len_q - WIN_W'(1) || !start) begin
                  state   <= DRAIN;
                  collect <= 1'b0;
               end
            end
            DRAIN: begin
               if (level == '0 && !wr_acc) begin
                  state     <= DONE;
                  coll_done <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   coll_ring_buf #(
      .W     (ENT_W),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk350  (clk350),
      .rstn    (rstn),
      .clr     (buf_clr),
      .wr_req  (collect & din_vld),
      .wr_data (entry),
      .rd_rdy  (rd_rdy),
      .rd_data (rd_data),
      .rd_vld  (rd_vld),
      .level   (level),
      .wr_acc  (wr_acc),
      .drop    (drop)
   );

endmodule

// File: tb/tb_coll_capture_ctrl.sv
// Directed bench for coll_capture_ctrl (default build, DEPTH=16).
module tb_coll_capture_ctrl;

   logic        clk350 = 1'b0;
   logic        rstn = 1'b1;
   logic        start_coll_async = 1'b0;
   logic [31:0] win_len = '0;
   logic [15:0] din = '0;
   logic        din_vld = 1'b0;
   logic        rd_rdy = 1'b0;
   logic        collect;
`ifdef COLL_TSTAMP_EN
   logic [31:0] rd_data;
`else
   logic [15:0] rd_data;
`endif
   logic        rd_vld;
   logic [4:0]  level;
   logic        overflow;
   logic        coll_done;

   coll_capture_ctrl #(
      .DATA_W      (16),
      .DEPTH       (16),
      .WIN_W       (32),
      .SYNC_STAGES (2)
   ) dut (
      .clk350           (clk350),
      .rstn             (rstn),
      .start_coll_async (start_coll_async),
      .win_len          (win_len),
      .din              (din),
      .din_vld          (din_vld),
      .collect          (collect),
      .rd_data          (rd_data),
      .rd_vld           (rd_vld),
      .rd_rdy           (rd_rdy),
      .level            (level),
      .overflow         (overflow),
      .coll_done        (coll_done)
   );

   always #2 clk350 = ~clk350;

   int checks = 0;
   int failures = 0;
   int cyc;
   int n_coll, first_coll, last_coll, n_done, done_cyc, n_rdvld, max_lvl;
   int ovf_done, lvl_probe, ovf_probe, dat_probe;
   logic [15:0] rdq [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk350);
      #1;
      cyc++;
   endtask

   // One run: start rises just after edge 0; outputs sampled 1 time unit after each edge.
   task automatic run(input int len, input int drop_at, input int rdy_at, input int probe_at,
                      input int base);
      int post;
      n_coll = 0; first_coll = -1; last_coll = -1; n_done = 0; done_cyc = -1;
      n_rdvld = 0; max_lvl = 0; ovf_done = -1; lvl_probe = -1; ovf_probe = -1; dat_probe = -1;
      rdq.delete();
      cyc = 0; post = 0;
      din = 16'(base); din_vld = 1'b1; rd_rdy = (rdy_at == 0);
      win_len = 32'(len); start_coll_async = 1'b1;
      for (int i = 0; i < 400 && post < 6; i++) begin
         step();
         if (collect) begin
            n_coll++;
            if (first_coll < 0) first_coll = cyc;
            last_coll = cyc;
         end
         if (coll_done) begin
            n_done++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               ovf_done = int'(overflow);
            end
         end
         if (rd_vld) n_rdvld++;
         if (int'(level) > max_lvl) max_lvl = int'(level);
         if (cyc == probe_at) begin
            lvl_probe = int'(level);
            ovf_probe = int'(overflow);
            dat_probe = int'(rd_data[15:0]);
         end
         if (n_done > 0) post++;
         din = 16'(base + cyc);
         if (drop_at > 0 && cyc >= drop_at) start_coll_async = 1'b0;
         rd_rdy = (cyc >= rdy_at);
         if (rd_vld && rd_rdy) rdq.push_back(rd_data[15:0]);
      end
      start_coll_async = 1'b0; din_vld = 1'b0; rd_rdy = 1'b0;
      repeat (6) step();
   endtask

   task automatic check_run(input string nm, input int e_ncoll, input int e_first, input int e_nrd,
                            input int e_done, input int e_ovf, input int e_lvl, input int e_dat,
                            input bit use_dat, input int base);
      chk({nm, ".collect_cycles"}, 32'(n_coll), 32'(e_ncoll));
      chk({nm, ".collect_first"}, 32'(first_coll), 32'(e_first));
      chk({nm, ".done_pulses"}, 32'(n_done), 32'd1);
      chk({nm, ".done_cycle"}, 32'(done_cyc), 32'(e_done));
      chk({nm, ".overflow_at_done"}, 32'(ovf_done), 32'(e_ovf));
      chk({nm, ".overflow_probe"}, 32'(ovf_probe), 32'(e_ovf));
      chk({nm, ".level_probe"}, 32'(lvl_probe), 32'(e_lvl));
      if (use_dat) chk({nm, ".rd_data_probe"}, 32'(dat_probe), 32'(base + e_dat));
      chk({nm, ".read_count"}, 32'(rdq.size()), 32'(e_nrd));
      for (int i = 0; i < rdq.size(); i++)
         chk({nm, ".read_data"}, 32'(rdq[i]), 32'(16'(base + 4 + i)));
   endtask

   initial begin
      cyc = 0;
      repeat (3) step();
      chk("reset.collect", 32'(collect), 32'd0);
      chk("reset.rd_vld", 32'(rd_vld), 32'd0);
      chk("reset.level", 32'(level), 32'd0);
      chk("reset.overflow", 32'(overflow), 32'd0);
      chk("reset.coll_done", 32'(coll_done), 32'd0);
      rstn = 1'b0;
      repeat (3) step();

      // Basic streaming run, 100-cycle window
      run(100, -1, 0, 50, 16'h0100);
      check_run("basic", 100, 4, 100, 106, 0, 1, 49, 1'b1, 16'h0100);

      // Overflow: no reads until well after the window closes
      run(40, -1, 60, 59, 16'h0200);
      check_run("overflow", 40, 4, 16, 77, 1, 16, 4, 1'b1, 16'h0200);
      chk("overflow.max_level", 32'(max_lvl), 32'd16);

      // Abort: start drops 50 cycles after collect rises
      run(1000, 54, 0, 30, 16'h0300);
      check_run("abort", 53, 4, 53, 59, 0, 1, 29, 1'b1, 16'h0300);
      chk("abort.collect_last", 32'(last_coll), 32'd56);

      // Zero-length window
      run(0, -1, 0, 2, 16'h0400);
      check_run("zero", 0, -1, 0, 4, 0, 0, 0, 1'b0, 16'h0400);
      chk("zero.rd_vld_cycles", 32'(n_rdvld), 32'd0);

      // Full buffer with simultaneous read and write
      run(30, -1, 20, 21, 16'h0500);
      check_run("full_rw", 30, 4, 30, 51, 0, 16, 5, 1'b1, 16'h0500);
      chk("full_rw.max_level", 32'(max_lvl), 32'd16);

      // Reset mid-COLLECT, then a clean 8-cycle run
      cyc = 0; din_vld = 1'b1; rd_rdy = 1'b0; win_len = 32'd1000; start_coll_async = 1'b1;
      din = 16'h5000;
      repeat (12) begin
         step();
         din = 16'(16'h5000 + cyc);
      end
      chk("midrst.level_before", 32'(level), 32'd8);
      chk("midrst.collect_before", 32'(collect), 32'd1);
      #1 rstn = 1'b1;
      #1;
      chk("midrst.collect", 32'(collect), 32'd0);
      chk("midrst.rd_vld", 32'(rd_vld), 32'd0);
      chk("midrst.level", 32'(level), 32'd0);
      chk("midrst.overflow", 32'(overflow), 32'd0);
      chk("midrst.coll_done", 32'(coll_done), 32'd0);
      start_coll_async = 1'b0; din_vld = 1'b0;
      repeat (4) step();
      rstn = 1'b0;
      repeat (4) step();
      run(8, -1, 0, 10, 16'h1000);
      check_run("restart", 8, 4, 8, 14, 0, 1, 9, 1'b1, 16'h1000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/coll_capture_ctrl.md
Name: coll_capture_ctrl

Overview:
Capture-window controller and sample buffer in the clk350 domain, directly upstream of the top-level collection logic. It takes the StartColl level generated in the clk200 domain, synchronises it, and drives the Collect window. During the window it writes qualified samples into an internal ring buffer. The buffer is then drained to the consumer over a valid/ready interface, and completion is signalled.

Parameters:
DATA_W, 16, sample width in bits
DEPTH, 1024, buffer depth in samples; power of two, minimum 4
WIN_W, 32, width of the window-length counter
SYNC_STAGES, 2, flop stages on start_coll_async; minimum 2

Ports:
clk350  in  1  capture clock, 350 MHz
rstn  in  1  reset, asynchronous, active-high (asserted when 1)
start_coll_async  in  1  StartColl level from the clk200 domain; asynchronous to clk350
win_len  in  WIN_W  window length in clk350 cycles; sampled at ARM
din  in  DATA_W  sample data
din_vld  in  1  sample qualifier
collect  out  1  high while the window is open (Collect)
rd_data  out  DATA_W  buffered sample (DATA_W+16 wide when COLL_TSTAMP_EN is defined)
rd_vld  out  1  rd_data valid
rd_rdy  in  1  consumer ready
level  out  log2(DEPTH)+1  buffer fill count
overflow  out  1  sticky flag: at least one sample was dropped
coll_done  out  1  one-cycle pulse when the run completes

Behaviour:
- Reset (rstn=1, asynchronous): FSM=IDLE; sync chain=0; pointers and level=0; collect, rd_vld, overflow and coll_done=0.
- start is the output of the SYNC_STAGES synchroniser. Its rising edge is detected with one further register, giving a total latency of SYNC_STAGES+1 clk350 cycles.
- FSM states: IDLE, ARM, COLLECT, DRAIN, DONE.
- IDLE -> ARM on the start rising edge. An edge seen in any other state is ignored.
- ARM (1 cycle): latch win_len; clear the window counter, pointers, level and overflow. If the latched length is 0, go to DONE; otherwise go to COLLECT.
- COLLECT: collect=1 and the window counter increments every cycle.
  - The state exits to DRAIN when the counter equals len-1, so collect stays high for exactly len cycles.
  - The state also exits to DRAIN early if start drops (abort). collect falls in the cycle after the drop is detected.
- Write rule: a sample is written when collect=1, din_vld=1 and the buffer is not full. A write is also accepted when the buffer is full and a read happens in the same cycle. Otherwise the sample is dropped and overflow is set, and overflow stays set until the next ARM.
- Read rule (valid in every state except IDLE and ARM):
  - rd_vld=1 whenever level>0.
  - A transfer occurs when rd_vld and rd_rdy are both high.
  - rd_data is registered, shows the oldest sample, and holds stable while rd_vld=1 and rd_rdy=0.
- Reading during COLLECT is legal, which makes streaming operation possible.
- DRAIN -> DONE when level=0 and no write is pending.
- DONE (1 cycle): coll_done=1, then go to IDLE. The buffer is empty at this point.
- Level: updated the same cycle as the access; simultaneous read and write leave it unchanged.
- Pointer arithmetic: pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- Full = (level==DEPTH); empty = (level==0).
- A new run needs start to fall and then rise again. Holding start high after DONE does not retrigger.
- An asynchronous reset in the middle of a run discards all buffered data. No coll_done pulse is issued for the aborted run.

Optional Feature:
COLL_TSTAMP_EN
- Defined: each stored entry is {window_counter[15:0], din}, and rd_data is DATA_W+16 bits wide. The timestamp is the window cycle offset at the moment of the write; it saturates at 0xFFFF.
- Undefined: entries are din only, rd_data is DATA_W bits wide, and no timestamp logic exists.

Decomposition:
- Package coll_pkg holds:
  - the state enum coll_state_t {IDLE, ARM, COLLECT, DRAIN, DONE};
  - the TSTAMP_W=16 constant;
  - a function clog2 for the pointer and level widths.
- One sub-module, coll_ring_buf, contains the storage, pointers, level, full/empty logic and registered read output.
- The top level holds the synchroniser, the FSM and the window counter.

Test Plan:
- Basic run. Stimulus: win_len=100, din_vld=1 with an incrementing din, rd_rdy=1 throughout. Required: collect is high for exactly 100 cycles, 100 samples are read back in order, coll_done pulses once, overflow=0.
- Overflow. Stimulus: DEPTH=16, win_len=40, din_vld=1, rd_rdy=0. Required: level saturates at 16 and overflow=1. Once rd_rdy rises, the first 16 samples drain and coll_done pulses.
- Abort. Stimulus: win_len=1000; start drops 50 cycles after collect rises. Required: collect falls within SYNC_STAGES+1 cycles of the drop, only the captured samples drain, and coll_done pulses.
- Zero length. Stimulus: win_len=0. Required: collect never rises, coll_done pulses 2 cycles after the start edge is detected, and rd_vld stays 0.
- Full plus simultaneous read/write. Stimulus: buffer full with rd_rdy=1 and din_vld=1 in the same cycle. Required: the write is accepted, level stays at DEPTH, and overflow stays 0.
- Reset mid-COLLECT. Stimulus: pulse rstn, then restart with win_len=8. Required: all outputs go to their reset values immediately, exactly 8 new samples are read back, and no stale data appears.
